// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: FSM states,
// funct3 op encodings and small op-decoding helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // MUL yields the same low half either way, so it is treated as unsigned.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift/accumulate datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per cycle on unsigned magnitudes.
module muldiv_datapath #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic                      step_i,
    input  logic                      is_div_i,
    input  logic [DATA_WIDTH-1:0]     a_mag_i,
    input  logic [DATA_WIDTH-1:0]     b_mag_i,
    output logic [2*DATA_WIDTH-1:0]   acc_next_o
);
    localparam int W = DATA_WIDTH;

    // Upper half: partial product / partial remainder; lower half: multiplier / quotient bits.
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;
    logic           is_div_q;

    logic [W:0]     mul_sum;
    logic [W:0]     trial;
    logic [2*W-1:0] mul_next;
    logic [2*W-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
        trial    = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
        if (trial[W]) begin
            div_next = {acc_q[2*W-2:0], 1'b0};
        end else begin
            div_next = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        end
        acc_next_o = is_div_q ? div_next : mul_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else if (load_i) begin
            acc_q    <= {{W{1'b0}}, a_mag_i};
            opnd_q   <= b_mag_i;
            is_div_q <= is_div_i;
        end else if (step_i) begin
            acc_q    <= acc_next_o;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: accepts one op at a time, runs DATA_WIDTH
// iterations in the datapath and registers the sign-corrected result.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic                    flush,
    output logic                    busy,
    output logic                    stall,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     op_q;
    logic           neg_q;
    logic           done_q;
    logic [W-1:0]   result_q;

    logic [2:0]     op_in;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf, bypass, accept;
    logic [W-1:0]   bypass_res;
    logic [2*W-1:0] acc_next, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        op_in    = funct3[2:0];
        a_neg    = op_a_signed(op_in) & a[W-1];
        b_neg    = op_b_signed(op_in) & b[W-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op_is_div(op_in) && (b == '0);
        div_ovf  = op_is_div(op_in) && op_b_signed(op_in) && (a == MOST_NEG) && (b == '1);
        bypass   = div_zero || div_ovf;
        if (op_is_rem(op_in)) begin
            bypass_res = div_zero ? a : '0;
        end else begin
            bypass_res = div_zero ? '1 : MOST_NEG;
        end
        accept   = (state_q == IDLE) && start && !flush;
    end

    // neg_q already encodes quotient vs remainder sign, so one flag serves every op.
    always_comb begin
        prod_fix = neg_q ? -acc_next : acc_next;
        quo_fix  = neg_q ? -acc_next[W-1:0] : acc_next[W-1:0];
        rem_fix  = neg_q ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
        if (op_is_div(op_q)) begin
            final_res = op_is_rem(op_q) ? rem_fix : quo_fix;
        end else if (op_q == OP_MUL) begin
            final_res = prod_fix[W-1:0];
        end else begin
            final_res = prod_fix[2*W-1:W];
        end
    end

    muldiv_datapath #(
        .DATA_WIDTH(W)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && !bypass),
        .step_i     (state_q == BUSY),
        .is_div_i   (op_is_div(op_in)),
        .a_mag_i    (a_mag),
        .b_mag_i    (b_mag),
        .acc_next_o (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        neg_q <= op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
                        cnt_q <= '0;
                        if (bypass) begin
                            result_q <= bypass_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // The final step's result is fixed up as it is registered, so it is valid with done.
                        if (cnt_q == LAST_STEP) begin
                            result_q <= final_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == BUSY);
    assign stall  = ((state_q == IDLE) && start) || (state_q == BUSY);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// flush/reset/start-while-busy sequences, and random ops against an arithmetic model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(
        .DATA_WIDTH  (32),
        .FUNCT3_WIDTH(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct3(funct3),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference computed from the RV32M rules with 64-bit / native integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'h0, y});
        case (op)
            3'd0: begin p = {32'h0, x} * {32'h0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(x) / $signed(y));
            end
            3'd5: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(x) % $signed(y));
            end
            default: return (y == 32'h0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op[2] && y == 32'h0) return 1;
        if ((op == 3'd4 || op == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Starts an op in "cycle 0" and waits (bounded) for done; lat is the done cycle index.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] res, output int lat, output int nbusy,
                          output logic stall0, output logic stall_done);
        @(negedge clk);
        funct3 = op; a = av; b = bv; start = 1'b1;
        #1 stall0 = stall;
        lat = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) nbusy++;
        end while (!done && lat < 100);
        res = result;
        stall_done = stall;
    endtask

    vec_t        vecs[12];
    logic [31:0] res, prev;
    int          lat, nbusy;
    logic        st0, std;
    logic        saw_done;

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[5]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[8]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[9]  = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
        vecs[10] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1};
        vecs[11] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),  32'h0);
        check("reset_done",   32'(done),  32'h0);
        check("reset_stall",  32'(stall), 32'h0);
        check("reset_result", result,     32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, nbusy, st0, std);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), (vecs[i].lat == 33) ? 32'd32 : 32'd0);
            check($sformatf("vec%0d_stall_c0", i), 32'(st0), 32'h1);
            check($sformatf("vec%0d_stall_done", i), 32'(std), 32'h0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
            check($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
        end

        // start held high while BUSY with different operands must be ignored.
        @(negedge clk);
        funct3 = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        funct3 = 3'd0; a = 32'h1234_5678; b = 32'h0000_0010;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("busy_start_result",  result,    32'd333);
        check("busy_start_latency", 32'(lat),  32'd33);
        @(negedge clk);
        check("busy_start_no_queue", 32'(busy), 32'h0);

        // flush in cycle 10 of a DIV.
        prev = result;
        @(negedge clk);
        funct3 = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1;
        saw_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) saw_done = 1'b1;
        check("flush_busy",   32'(busy),     32'h0);
        check("flush_done",   32'(saw_done), 32'h0);
        check("flush_result", result,        prev);
        run_op(3'd4, 32'd100, 32'd7, res, lat, nbusy, st0, std);
        check("after_flush_result",  res,      32'd14);
        check("after_flush_latency", 32'(lat), 32'd33);

        // flush in IDLE outranks start.
        @(negedge clk);
        funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'h0);
        check("idle_flush_done", 32'(done), 32'h0);

        // Asynchronous reset in cycle 15 of a MUL.
        @(negedge clk);
        funct3 = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",   32'(busy), 32'h0);
        check("rst_mid_done",   32'(done), 32'h0);
        check("rst_mid_result", result,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd9, 32'd9, res, lat, nbusy, st0, std);
        check("after_rst_result",  res,      32'd81);
        check("after_rst_latency", 32'(lat), 32'd33);

        // Random ops with injected divide-by-zero and overflow corners.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] ra, rb;
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 7) == 0) rb = rb >> $urandom_range(16, 31);
            run_op(op, ra, rb, res, lat, nbusy, st0, std);
            check($sformatf("rand%0d_op%0d_result", i, op), res, model(op, ra, rb));
            check($sformatf("rand%0d_op%0d_latency", i, op), 32'(lat), 32'(model_lat(op, ra, rb)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter FUNCT3_WIDTH, default 3, operation select width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port funct3  input  FUNCT3_WIDTH  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port a  input  DATA_WIDTH  rs1 operand (multiplicand/dividend).
REQ-008 SHALL have port b  input  DATA_WIDTH  rs2 operand (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  abort the in-flight operation.
REQ-010 SHALL have port busy  output  1  high in BUSY state.
REQ-011 SHALL have port stall  output  1  pipeline hold request.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have port result  output  DATA_WIDTH  registered operation result.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 In IDLE with start=1, SHALL latch funct3, a and b, and SHALL convert signed operands to magnitudes according to the op signedness.
REQ-016 On that acceptance, SHALL move to BUSY with the iteration counter at 0.
REQ-017 Divide-by-zero and signed overflow (most-negative / -1) SHALL bypass BUSY and go IDLE->DONE directly.
REQ-018 In BUSY, SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
REQ-019 The counter SHALL increment each BUSY cycle, and the FSM SHALL move to DONE when it reaches DATA_WIDTH-1, giving exactly DATA_WIDTH BUSY cycles.
REQ-020 Latency: accepted start in cycle 0 -> done in cycle DATA_WIDTH+1 (33); bypass cases -> done in cycle 1.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, apply sign fix-up, update result, and return to IDLE.
REQ-022 MUL SHALL return the low DATA_WIDTH bits of the 2*DATA_WIDTH product; MULH, MULHSU and MULHU SHALL return the high DATA_WIDTH bits with the respective operand signedness.
REQ-023 Quotient sign SHALL be sign(a) XOR sign(b), and remainder sign SHALL be sign(a), for DIV and REM.
REQ-024 Divide by zero SHALL give quotient all-ones and remainder = a.
REQ-025 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-026 stall SHALL be combinational: (state==IDLE & start) | (state==BUSY); it SHALL be low in DONE.
REQ-027 busy SHALL equal (state==BUSY).
REQ-028 start while BUSY or DONE SHALL be ignored; no queuing.
REQ-029 result SHALL hold its value from DONE until the next DONE.
REQ-030 flush in BUSY or DONE SHALL force IDLE next cycle, suppress done, and leave result unchanged.
REQ-031 flush in IDLE SHALL take priority over start: no acceptance.
REQ-032 Internal product/remainder registers SHALL be 2*DATA_WIDTH wide; no overflow is possible.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, counter 0, result 0, done 0, and internal operand/accumulator registers 0.
REQ-034 Reset mid-BUSY SHALL abort without a done pulse.
REQ-035 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Structure
REQ-036 Package muldiv_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the eight funct3 op constants.
REQ-037 One sub-module muldiv_datapath SHALL hold the shift/accumulate registers and per-step arithmetic.
REQ-038 The FSM, counter and sign fix-up control SHALL live in muldiv_sequencer.

Verification
REQ-039 MUL a=7, b=0xFFFFFFFD -> stall in cycle 0, busy cycles 1-32, done in cycle 33, result 0xFFFFFFEB.
REQ-040 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> result 0x00000000.
REQ-041 DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD; REM with the same operands -> result 0xFFFFFFFF.
REQ-042 DIVU a=5, b=0 -> done in cycle 1, result 0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM with the same operands -> result 0.
REQ-043 flush in cycle 10 of a DIV -> IDLE in cycle 11, no done, result unchanged; a new start in cycle 12 completes normally.
REQ-044 rst_n low in cycle 15 of a MUL -> busy=0, done=0, result=0 immediately; start accepted after release.
